// File: rtl/spr_de_gamma_interp.sv
// spr_de_gamma_interp
//   Per-channel de-gamma. A shared knot table maps gamma-domain codes to
//   linear-domain codes by piecewise-linear interpolation. The datapath is a
//   three-stage pipeline with one global stall enable.
//
// Ports
//   clk, reset              single clock; synchronous active-high reset
//   s_valid/s_ready/s_pix   input pixel stream, channel 0 in the LSBs
//   m_valid/m_ready/m_pix   output pixel stream, channel 0 in the LSBs
//   cfg_bypass              per-pixel bypass, sampled when the pixel is accepted
//   cfg_we/cfg_addr/cfg_wdata  knot table write port
//   cfg_rdata               registered readback of knot[cfg_addr]
module spr_de_gamma_interp #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 11,
    parameter int SEG_BITS = 5,
    parameter int CH       = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CH*IN_W-1:0]    s_pix,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CH*OUT_W-1:0]   m_pix,
    input  logic                  cfg_bypass,
    input  logic                  cfg_we,
    input  logic [SEG_BITS:0]     cfg_addr,
    input  logic [OUT_W-1:0]      cfg_wdata,
    output logic [OUT_W-1:0]      cfg_rdata
);
    localparam int FRAC_W   = IN_W - SEG_BITS;
    localparam int KNOTS    = (1 << SEG_BITS) + 1;
    localparam int ADDR_W   = SEG_BITS + 1;
    // Signed width wide enough for (up - lo) * frac and for lo + that / 2^FRAC_W.
    localparam int PROD_W   = OUT_W + FRAC_W + 2;
    localparam int SHIFT_UP = OUT_W - IN_W;
    localparam logic signed [PROD_W-1:0] OUT_MAX = PROD_W'((1 << OUT_W) - 1);

    // Identity-like default curve; the last knot saturates at full scale.
    function automatic logic [OUT_W-1:0] knot_default(input int k);
        int v;
        v = k << (OUT_W - SEG_BITS);
        if (v > (1 << OUT_W) - 1)
            return '1;
        return v[OUT_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Knot table: plain registers, written regardless of pipeline stalls.
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] knot_reg [KNOTS];
    logic             addr_ok;

    assign addr_ok = (int'(cfg_addr) < KNOTS);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < KNOTS; k++)
                knot_reg[k] <= knot_default(k);
            cfg_rdata <= '0;
        end else begin
            if (cfg_we && addr_ok)
                knot_reg[cfg_addr] <= cfg_wdata;
            // Reads the pre-write value on a same-edge write.
            cfg_rdata <= addr_ok ? knot_reg[cfg_addr] : '0;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline control: every stage advances together when en is high.
    // ------------------------------------------------------------------
    logic en;
    logic v1_reg, v2_reg, v3_reg;
    logic byp1_reg, byp2_reg;

    assign en      = !v3_reg || m_ready;
    assign s_ready = en;
    assign m_valid = v3_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_reg   <= 1'b0;
            v2_reg   <= 1'b0;
            v3_reg   <= 1'b0;
            byp1_reg <= 1'b0;
            byp2_reg <= 1'b0;
        end else if (en) begin
            v1_reg   <= s_valid;
            byp1_reg <= cfg_bypass;
            v2_reg   <= v1_reg;
            byp2_reg <= byp1_reg;
            v3_reg   <= v2_reg;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel datapath
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [SEG_BITS-1:0]      idx;
        logic [FRAC_W-1:0]        frac;
        logic [ADDR_W-1:0]        lo_addr;
        logic [ADDR_W-1:0]        up_addr;
        logic [OUT_W-1:0]         lo1_reg, up1_reg, lo2_reg;
        logic [FRAC_W-1:0]        frac1_reg;
        logic [IN_W-1:0]          pix1_reg, pix2_reg;
        logic signed [PROD_W-1:0] diff, frac_s, prod_next, prod2_reg, sum;
        logic [OUT_W-1:0]         res_next, res_reg;

        assign idx     = s_pix[gi*IN_W + FRAC_W +: SEG_BITS];
        assign frac    = s_pix[gi*IN_W +: FRAC_W];
        assign lo_addr = {1'b0, idx};
        assign up_addr = lo_addr + ADDR_W'(1);

        // S2 input: signed slope times unsigned fraction.
        always_comb begin
            diff      = $signed({{(PROD_W-OUT_W){1'b0}}, up1_reg})
                      - $signed({{(PROD_W-OUT_W){1'b0}}, lo1_reg});
            frac_s    = $signed({{(PROD_W-FRAC_W){1'b0}}, frac1_reg});
            prod_next = diff * frac_s;
        end

        // S3 input: floor-shifted product added to lo, clamped to code range.
        always_comb begin
            sum = $signed({{(PROD_W-OUT_W){1'b0}}, lo2_reg}) + (prod2_reg >>> FRAC_W);
            if (byp2_reg)
                res_next = OUT_W'(pix2_reg) << SHIFT_UP;
            else if (sum < 0)
                res_next = '0;
            else if (sum > OUT_MAX)
                res_next = '1;
            else
                res_next = sum[OUT_W-1:0];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                lo1_reg   <= '0;
                up1_reg   <= '0;
                frac1_reg <= '0;
                pix1_reg  <= '0;
                prod2_reg <= '0;
                lo2_reg   <= '0;
                pix2_reg  <= '0;
                res_reg   <= '0;
            end else if (en) begin
                lo1_reg   <= knot_reg[lo_addr];
                up1_reg   <= knot_reg[up_addr];
                frac1_reg <= frac;
                pix1_reg  <= s_pix[gi*IN_W +: IN_W];
                prod2_reg <= prod_next;
                lo2_reg   <= lo1_reg;
                pix2_reg  <= pix1_reg;
                res_reg   <= res_next;
            end
        end

        assign m_pix[gi*OUT_W +: OUT_W] = res_reg;
    end

endmodule

// File: tb/tb_spr_de_gamma_interp.sv
// Directed self-checking bench for spr_de_gamma_interp (default parameters).
module tb_spr_de_gamma_interp;
    localparam int IN_W = 8, OUT_W = 11, SEG_BITS = 5, CH = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 s_valid;
    logic                 s_ready;
    logic [CH*IN_W-1:0]   s_pix;
    logic                 m_valid;
    logic                 m_ready;
    logic [CH*OUT_W-1:0]  m_pix;
    logic                 cfg_bypass;
    logic                 cfg_we;
    logic [SEG_BITS:0]    cfg_addr;
    logic [OUT_W-1:0]     cfg_wdata;
    logic [OUT_W-1:0]     cfg_rdata;

    spr_de_gamma_interp #(.IN_W(IN_W), .OUT_W(OUT_W), .SEG_BITS(SEG_BITS), .CH(CH)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_pix(s_pix),
        .m_valid(m_valid), .m_ready(m_ready), .m_pix(m_pix),
        .cfg_bypass(cfg_bypass), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] p0, p1, p2;
        logic       byp;
        int         e0, e1, e2;
    } vec_t;

    vec_t vecs[6];
    int   errors = 0;
    int   checks = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ch_out(input int c);
        return 32'(m_pix[c*OUT_W +: OUT_W]);
    endfunction

    function automatic logic [CH*IN_W-1:0] pk(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c);
        return {c, b, a};
    endfunction

    task automatic write_knot(input int addr, input int val);
        cfg_we    = 1'b1;
        cfg_addr  = (SEG_BITS+1)'(addr);
        cfg_wdata = OUT_W'(val);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic read_knot(input string name, input int addr, input int exp);
        cfg_addr = (SEG_BITS+1)'(addr);
        tick();
        check(name, 32'(cfg_rdata), exp);
    endtask

    task automatic send(input logic [CH*IN_W-1:0] pix, input logic byp);
        s_pix      = pix;
        cfg_bypass = byp;
        s_valid    = 1'b1;
        tick();
        s_valid    = 1'b0;
        cfg_bypass = 1'b0;
        s_pix      = '0;
    endtask

    // Called right after the acceptance edge; returns the cycle index at which
    // m_valid was first seen (acceptance cycle = 0).
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!m_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int sent, got, stall;

        vecs[0] = '{p0: 8'd0,   p1: 8'd0,   p2: 8'd0,   byp: 1'b0, e0: 0,    e1: 0,    e2: 0};
        vecs[1] = '{p0: 8'd100, p1: 8'd255, p2: 8'd8,   byp: 1'b0, e0: 800,  e1: 2039, e2: 64};
        vecs[2] = '{p0: 8'd7,   p1: 8'd128, p2: 8'd200, byp: 1'b0, e0: 56,   e1: 1024, e2: 1600};
        vecs[3] = '{p0: 8'd1,   p1: 8'd15,  p2: 8'd254, byp: 1'b0, e0: 8,    e1: 120,  e2: 2031};
        vecs[4] = '{p0: 8'hFF,  p1: 8'h01,  p2: 8'h00,  byp: 1'b1, e0: 2040, e1: 8,    e2: 0};
        vecs[5] = '{p0: 8'h80,  p1: 8'h55,  p2: 8'hFE,  byp: 1'b1, e0: 1024, e1: 680,  e2: 2032};

        reset = 1'b1; s_valid = 1'b0; s_pix = '0; m_ready = 1'b0;
        cfg_bypass = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        tick();
        tick();
        check("reset_m_valid", 32'(m_valid), 0);
        check("reset_m_pix", 32'(m_pix), 0);
        check("reset_cfg_rdata", 32'(cfg_rdata), 0);
        reset = 1'b0;
        #1;
        check("reset_s_ready", 32'(s_ready), 1);
        m_ready = 1'b1;

        // Default knot table readback.
        for (int k = 0; k <= 32; k++)
            read_knot($sformatf("default_knot_%0d", k), k, (k * 64 > 2047) ? 2047 : k * 64);

        // Table-driven single pixels with latency check.
        for (int i = 0; i < 6; i++) begin
            send(pk(vecs[i].p0, vecs[i].p1, vecs[i].p2), vecs[i].byp);
            wait_valid(lat);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_ch0", i), ch_out(0), vecs[i].e0);
            check($sformatf("vec%0d_ch1", i), ch_out(1), vecs[i].e1);
            check($sformatf("vec%0d_ch2", i), ch_out(2), vecs[i].e2);
        end
        tick();

        // Back-to-back stream 0, 100, 255.
        s_valid = 1'b1;
        s_pix = pk(8'd0, 8'd0, 8'd0);   tick();
        s_pix = pk(8'd100, 8'd0, 8'd0); tick();
        s_pix = pk(8'd255, 8'd0, 8'd0); tick();
        s_valid = 1'b0; s_pix = '0;
        check("b2b_valid0", 32'(m_valid), 1);
        check("b2b_ch0_0", ch_out(0), 0);
        tick();
        check("b2b_valid1", 32'(m_valid), 1);
        check("b2b_ch0_1", ch_out(0), 800);
        tick();
        check("b2b_valid2", 32'(m_valid), 1);
        check("b2b_ch0_2", ch_out(0), 2039);
        tick();
        check("b2b_drain", 32'(m_valid), 0);

        // Write knot[13] on the same edge a pixel is looked up: that pixel
        // sees the old table, the next one sees the new value.
        s_valid = 1'b1; s_pix = pk(8'd100, 8'd0, 8'd0);
        cfg_we = 1'b1; cfg_addr = 6'd13; cfg_wdata = 11'd100;
        tick();
        cfg_we = 1'b0;
        check("rdata_old_on_write", 32'(cfg_rdata), 832);
        tick();
        s_valid = 1'b0; s_pix = '0;
        check("rdata_new", 32'(cfg_rdata), 100);
        tick();
        check("wr_before_valid", 32'(m_valid), 1);
        check("wr_before_ch0", ch_out(0), 800);
        tick();
        check("wr_after_valid", 32'(m_valid), 1);
        check("wr_after_ch0", ch_out(0), 434);
        tick();
        write_knot(13, 832);

        // Top segment, rising then falling slope.
        write_knot(31, 0);
        write_knot(32, 2047);
        send(pk(8'd255, 8'd0, 8'd0), 1'b0);
        wait_valid(lat);
        check("rise_latency", lat, 3);
        check("rise_ch0", ch_out(0), 1791);
        write_knot(32, 0);
        write_knot(31, 2047);
        send(pk(8'd248, 8'd255, 8'd252), 1'b0);
        wait_valid(lat);
        check("fall_latency", lat, 3);
        check("fall_ch0", ch_out(0), 2047);
        check("fall_ch1_floor", ch_out(1), 255);
        check("fall_ch2", ch_out(2), 1023);

        // Out-of-range write ignored; out-of-range read returns 0.
        write_knot(33, 999);
        read_knot("oor_no_alias", 1, 64);
        read_knot("oor_read", 33, 0);
        read_knot("oor_knot32", 32, 0);

        // Five-pixel stream with a 4-cycle output stall after the first output.
        sent = 0; got = 0; stall = 0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            s_valid = (sent < 5);
            s_pix   = pk(8'(10 * (sent + 1)), 8'(8 * sent), 8'd0);
            m_ready = !(got == 1 && stall < 4);
            #1;
            if (m_valid && !m_ready) begin
                stall++;
                check("stall_s_ready", 32'(s_ready), 0);
                check("stall_hold_ch0", ch_out(0), 160);
                check("stall_hold_ch1", ch_out(1), 64);
            end else if (m_valid && m_ready) begin
                check($sformatf("stream%0d_ch0", got), ch_out(0), 80 * (got + 1));
                check($sformatf("stream%0d_ch1", got), ch_out(1), 64 * got);
                got++;
            end
            if (s_valid && s_ready)
                sent++;
            tick();
        end
        s_valid = 1'b0; m_ready = 1'b1; s_pix = '0;
        check("stream_sent", sent, 5);
        check("stream_got", got, 5);
        check("stream_stalls", stall, 4);
        check("stream_no_dup0", 32'(m_valid), 0);
        tick();
        tick();
        check("stream_no_dup1", 32'(m_valid), 0);

        // Reset with three pixels in flight and knot[5] reprogrammed.
        write_knot(5, 7);
        s_valid = 1'b1;
        s_pix = pk(8'd40, 8'd0, 8'd0); tick();
        s_pix = pk(8'd41, 8'd0, 8'd0); tick();
        s_pix = pk(8'd42, 8'd0, 8'd0); tick();
        s_valid = 1'b0; s_pix = '0;
        check("pre_reset_valid", 32'(m_valid), 1);
        reset = 1'b1;
        m_ready = 1'b0;
        tick();
        check("midreset_m_valid", 32'(m_valid), 0);
        check("midreset_m_pix", 32'(m_pix), 0);
        check("midreset_rdata", 32'(cfg_rdata), 0);
        reset = 1'b0;
        #1;
        check("post_reset_s_ready", 32'(s_ready), 1);
        read_knot("post_reset_knot5", 5, 320);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_reset_idle%0d", i), 32'(m_valid), 0);
        end
        m_ready = 1'b1;
        send(pk(8'd40, 8'd0, 8'd0), 1'b0);
        wait_valid(lat);
        check("post_reset_latency", lat, 3);
        check("post_reset_ch0", ch_out(0), 320);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
